// File: rtl/cirno_exec_core.sv
// Cirno CPU fetch/decode/execute datapath.
// PC, instruction register, decoder, 8-bit ALU and compare flag.
module cirno_exec_core (
  input  logic       clk,
  input  logic       init,
  input  logic [7:0] start_address,
  input  logic       fetch_unit_en,
  input  logic       decoder_en,
  input  logic       alu_en,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [8:0] imem_data,
  output logic [7:0] imem_addr,
  output logic [8:0] inst,
  output logic [2:0] inst_type,
  output logic [3:0] funct,
  output logic [5:0] immediate,
  output logic [1:0] r1,
  output logic [1:0] r2,
  output logic       y_is_imm,
  output logic       is_cmp,
  output logic       eq,
  output logic       cmp,
  output logic       jump,
  output logic       branch,
  output logic       branchi,
  output logic [7:0] result,
  output logic       done
);

  logic [7:0] pc_q, result_q, alu_d;
  logic [8:0] inst_q;
  logic [2:0] type_q, type_d;
  logic [3:0] funct_q, funct_d;
  logic [5:0] imm_q;
  logic [1:0] r1_q, r1_d, r2_q, r2_d;
  logic [1:0] mvsel_q, mvsel_d;
  logic       yimm_q, yimm_d, iscmp_q, iscmp_d;
  logic       jump_q, jump_d, branch_q, branch_d;
  logic       jmpi_q, jmpi_d, beqi_q, beqi_d;
  logic       halt_d, cmp_q, done_q;

  // Fetch target: register jump, relative jump, or sequential PC.
  always_comb begin
    imem_addr = pc_q;
    if (jump_q || (branch_q && cmp_q))
      imem_addr = x;
    else if (jmpi_q || (beqi_q && cmp_q))
      imem_addr = pc_q - 8'd1 + {{2{imm_q[5]}}, imm_q};
  end

  // Decode the held instruction into its control fields.
  always_comb begin
    type_d   = 3'd0;
    funct_d  = 4'd0;
    r1_d     = 2'd0;
    r2_d     = 2'd0;
    mvsel_d  = 2'd0;
    yimm_d   = 1'b0;
    iscmp_d  = 1'b0;
    jump_d   = 1'b0;
    branch_d = 1'b0;
    jmpi_d   = 1'b0;
    beqi_d   = 1'b0;
    halt_d   = 1'b0;
    if (inst_q[8]) begin
      funct_d = inst_q[7:4];
      r1_d    = inst_q[3:2];
      r2_d    = inst_q[1:0];
      yimm_d  = (funct_d >= 4'd8) && (funct_d <= 4'd10);
      iscmp_d = (funct_d == 4'd6);
      case (funct_d)
        4'd11: type_d = 3'd4;
        4'd12: begin type_d = 3'd3; jump_d = 1'b1; end
        4'd13: begin type_d = 3'd3; branch_d = 1'b1; end
        4'd14: type_d = 3'd5;
        4'd15: type_d = 3'd6;
        default: type_d = 3'd1;
      endcase
    end else begin
      case (inst_q[7:6])
        2'b00: begin type_d = 3'd4; mvsel_d = 2'd1; end
        2'b01: begin type_d = 3'd4; mvsel_d = 2'd2; end
        2'b10: begin
          type_d = 3'd2;
          halt_d = (inst_q[5:0] == 6'd0);
          jmpi_d = ~halt_d;
        end
        default: begin
          type_d = 3'd2;
          beqi_d = (inst_q[5:0] != 6'd0);
        end
      endcase
    end
  end

  // Execute: ALU and move results for the decoded instruction.
  always_comb begin
    alu_d = result_q;
    if (type_q == 3'd1) begin
      case (funct_q)
        4'd0:  alu_d = x + y;
        4'd1:  alu_d = x - y;
        4'd2:  alu_d = x & y;
        4'd3:  alu_d = x | y;
        4'd4:  alu_d = x ^ y;
        4'd5:  alu_d = y[7] ? (x >> y[2:0]) : (x << y[2:0]);
        4'd6:  alu_d = 8'd0;
        4'd7:  alu_d = x + {7'd0, cmp_q};
        4'd8:  alu_d = x & ((8'd2 << r2_q) - 8'd1);
        4'd9:  alu_d = x << ({1'b0, r2_q} + 3'd1);
        4'd10: alu_d = x >> ({1'b0, r2_q} + 3'd1);
        default: alu_d = result_q;
      endcase
    end else if (type_q == 3'd4) begin
      case (mvsel_q)
        2'd1:    alu_d = {2'b00, imm_q};
        2'd2:    alu_d = {imm_q[1:0], x[5:0]};
        default: alu_d = y;
      endcase
    end
  end

  // State update; init wins over all strobes.
  always_ff @(posedge clk) begin
    if (init) begin
      pc_q     <= start_address;
      inst_q   <= 9'd0;
      type_q   <= 3'd0;
      funct_q  <= 4'd0;
      imm_q    <= 6'd0;
      r1_q     <= 2'd0;
      r2_q     <= 2'd0;
      mvsel_q  <= 2'd0;
      yimm_q   <= 1'b0;
      iscmp_q  <= 1'b0;
      jump_q   <= 1'b0;
      branch_q <= 1'b0;
      jmpi_q   <= 1'b0;
      beqi_q   <= 1'b0;
      result_q <= 8'd0;
      cmp_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (fetch_unit_en) begin
        inst_q <= imem_data;
        pc_q   <= imem_addr + 8'd1;
      end
      if (decoder_en) begin
        type_q   <= type_d;
        funct_q  <= funct_d;
        imm_q    <= inst_q[5:0];
        r1_q     <= r1_d;
        r2_q     <= r2_d;
        mvsel_q  <= mvsel_d;
        yimm_q   <= yimm_d;
        iscmp_q  <= iscmp_d;
        jump_q   <= jump_d;
        branch_q <= branch_d;
        jmpi_q   <= jmpi_d;
        beqi_q   <= beqi_d;
        if (halt_d) done_q <= 1'b1;
      end
      if (alu_en) begin
        result_q <= alu_d;
        if (iscmp_q) cmp_q <= (x == y);
      end
    end
  end

  assign inst      = inst_q;
  assign inst_type = type_q;
  assign funct     = funct_q;
  assign immediate = imm_q;
  assign r1        = r1_q;
  assign r2        = r2_q;
  assign y_is_imm  = yimm_q;
  assign is_cmp    = iscmp_q;
  assign eq        = (x == y);
  assign cmp       = cmp_q;
  assign jump      = jump_q;
  assign branch    = branch_q;
  assign branchi   = jmpi_q | beqi_q;
  assign result    = result_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cirno_exec_core.sv
// Bench for cirno_exec_core.
// Directed scenarios plus random ALU/move traffic against a model.
module tb_cirno_exec_core;
  logic       clk = 1'b0;
  logic       init, fetch_unit_en, decoder_en, alu_en;
  logic [7:0] start_address, x, y;
  logic [8:0] imem_data;
  logic [7:0] imem_addr, result;
  logic [8:0] inst;
  logic [2:0] inst_type;
  logic [3:0] funct;
  logic [5:0] immediate;
  logic [1:0] r1, r2;
  logic       y_is_imm, is_cmp, eq, cmp;
  logic       jump, branch, branchi, done;

  logic [8:0] imem [256];
  int vec = 0;
  int miss = 0;
  logic [7:0] m_pc, m_res;
  logic       m_cmp;

  always #5 clk = ~clk;
  assign imem_data = imem[imem_addr];

  cirno_exec_core dut (
    .clk(clk), .init(init), .start_address(start_address),
    .fetch_unit_en(fetch_unit_en), .decoder_en(decoder_en),
    .alu_en(alu_en), .x(x), .y(y), .imem_data(imem_data),
    .imem_addr(imem_addr), .inst(inst), .inst_type(inst_type),
    .funct(funct), .immediate(immediate), .r1(r1), .r2(r2),
    .y_is_imm(y_is_imm), .is_cmp(is_cmp), .eq(eq), .cmp(cmp),
    .jump(jump), .branch(branch), .branchi(branchi),
    .result(result), .done(done)
  );

  function automatic logic [7:0] exp_res(logic [8:0] ins,
      logic [7:0] a, logic [7:0] b, logic c, logic [7:0] prev);
    int xa, yb, k, imm, sa, r;
    xa = a; yb = b; k = ins[1:0]; imm = ins[5:0]; sa = b[2:0];
    r = prev;
    if (ins[8]) begin
      case (ins[7:4])
        4'd0:  r = xa + yb;
        4'd1:  r = xa - yb + 256;
        4'd2:  r = a & b;
        4'd3:  r = a | b;
        4'd4:  r = a ^ b;
        4'd5:  r = b[7] ? xa / (2 ** sa) : xa * (2 ** sa);
        4'd6:  r = 0;
        4'd7:  r = xa + c;
        4'd8:  r = xa % (2 ** (k + 1));
        4'd9:  r = xa * (2 ** (k + 1));
        4'd10: r = xa / (2 ** (k + 1));
        4'd11: r = yb;
        default: r = prev;
      endcase
    end else if (ins[7:6] == 2'b00) r = imm;
    else r = (imm % 4) * 64 + xa % 64;
    return 8'(r % 256);
  endfunction

  function automatic logic [2:0] exp_type(logic [8:0] ins);
    if (!ins[8]) return (ins[7] ? 3'd2 : 3'd4);
    if (ins[7:4] <= 4'd10) return 3'd1;
    if (ins[7:4] == 4'd11) return 3'd4;
    if (ins[7:4] <= 4'd13) return 3'd3;
    return (ins[7:4] == 4'd14) ? 3'd5 : 3'd6;
  endfunction

  task automatic tick(input logic f, input logic d, input logic a);
    fetch_unit_en = f; decoder_en = d; alu_en = a;
    @(posedge clk); #1;
    fetch_unit_en = 0; decoder_en = 0; alu_en = 0;
  endtask

  task automatic do_init(input logic [7:0] sa);
    start_address = sa; init = 1;
    @(posedge clk); #1;
    init = 0;
    m_pc = sa; m_cmp = 0; m_res = 0;
  endtask

  task automatic run(input logic [8:0] ins,
                     input logic [7:0] xv, input logic [7:0] yv);
    imem[m_pc] = ins; x = xv; y = yv;
    tick(1, 0, 0);
    m_pc = m_pc + 8'd1;
    tick(0, 1, 0);
    tick(0, 0, 1);
  endtask

  task automatic test_reset;
    fetch_unit_en = 1; decoder_en = 1; alu_en = 1;
    start_address = 8'h10; init = 1;
    @(posedge clk); #1;
    init = 0; fetch_unit_en = 0; decoder_en = 0; alu_en = 0;
    m_pc = 8'h10; m_cmp = 0; m_res = 0;
    vec++; if (imem_addr !== 8'h10) begin miss++;
      $display("FAIL reset_addr: got %h want 10", imem_addr); end
    vec++; if (inst !== 9'd0) begin miss++;
      $display("FAIL reset_inst: got %h want 0", inst); end
    vec++; if ({done, cmp, result, inst_type} !== 13'd0) begin miss++;
      $display("FAIL reset_regs: got %b/%b/%h/%0d want 0",
               done, cmp, result, inst_type); end
    imem[8'h10] = 9'h1A5;
    tick(1, 0, 0);
    m_pc = 8'h11;
    vec++; if (inst !== 9'h1A5) begin miss++;
      $display("FAIL first_fetch: got %h want 1a5", inst); end
    vec++; if (imem_addr !== 8'h11) begin miss++;
      $display("FAIL pc_after_fetch: got %h want 11", imem_addr); end
  endtask

  task automatic test_add;
    run(9'b1_0000_01_10, 8'd200, 8'd100);
    vec++; if ({inst_type, r1, r2, funct} !== {3'd1, 2'd1, 2'd2, 4'd0})
    begin miss++;
      $display("FAIL add_decode: got t%0d r%0d r%0d f%0d want 1 1 2 0",
               inst_type, r1, r2, funct); end
    vec++; if (result !== 8'd44) begin miss++;
      $display("FAIL add_result: got %0d want 44", result); end
  endtask

  task automatic test_cmp_beqi;
    do_init(8'h1F);
    run(9'b1_0110_00_00, 8'd5, 8'd5);
    vec++; if ({cmp, is_cmp, result} !== {2'b11, 8'd0}) begin miss++;
      $display("FAIL cmp_eq: got cmp%b is%b res%h want 1 1 00",
               cmp, is_cmp, result); end
    imem[8'h20] = 9'b0_11_111110;
    tick(1, 0, 0);
    tick(0, 1, 0);
    vec++; if ({branchi, inst_type} !== {1'b1, 3'd2}) begin miss++;
      $display("FAIL beqi_decode: got bi%b t%0d want 1 2",
               branchi, inst_type); end
    vec++; if (imem_addr !== 8'h1E) begin miss++;
      $display("FAIL beqi_target: got %h want 1e", imem_addr); end
    imem[8'h1E] = 9'h0C3;
    tick(1, 0, 0);
    vec++; if (inst !== 9'h0C3) begin miss++;
      $display("FAIL beqi_fetch: got %h want 0c3", inst); end
  endtask

  task automatic test_jmp_beq;
    do_init(8'h30);
    x = 8'h40;
    imem[8'h30] = 9'b1_1100_00_00;
    tick(1, 0, 0);
    tick(0, 1, 0);
    vec++; if ({jump, inst_type, imem_addr} !== {1'b1, 3'd3, 8'h40})
    begin miss++;
      $display("FAIL jmp_target: got j%b t%0d a%h want 1 3 40",
               jump, inst_type, imem_addr); end
    imem[8'h40] = 9'b1_0000_01_10;
    tick(1, 0, 0);
    tick(0, 1, 0);
    vec++; if (imem_addr !== 8'h41) begin miss++;
      $display("FAIL jmp_pc: got %h want 41", imem_addr); end
    imem[8'h41] = 9'b1_1101_00_00;
    x = 8'h77;
    tick(1, 0, 0);
    tick(0, 1, 0);
    vec++; if ({branch, imem_addr} !== {1'b1, 8'h42}) begin miss++;
      $display("FAIL beq_not_taken: got b%b a%h want 1 42",
               branch, imem_addr); end
  endtask

  task automatic test_shifts;
    do_init(8'h50);
    run(9'b1_0101_00_00, 8'h81, 8'h83);
    vec++; if (result !== 8'h10) begin miss++;
      $display("FAIL sh_right: got %h want 10", result); end
    run(9'b1_1001_00_11, 8'h01, 8'hAA);
    vec++; if ({y_is_imm, result} !== {1'b1, 8'h10}) begin miss++;
      $display("FAIL shli: got yi%b %h want 1 10", y_is_imm, result); end
    run(9'b1_0110_00_00, 8'd9, 8'd9);
    run(9'b1_0111_00_00, 8'hFF, 8'h00);
    vec++; if (result !== 8'h00) begin miss++;
      $display("FAIL incc_wrap: got %h want 00", result); end
  endtask

  task automatic test_halt;
    do_init(8'h60);
    imem[8'h60] = 9'b0_10_000000;
    tick(1, 0, 0);
    tick(0, 1, 0);
    vec++; if ({done, inst_type} !== {1'b1, 3'd2}) begin miss++;
      $display("FAIL halt: got d%b t%0d want 1 2", done, inst_type); end
    tick(1, 1, 1);
    vec++; if (done !== 1'b1) begin miss++;
      $display("FAIL halt_sticky: got %b want 1", done); end
    do_init(8'h60);
    vec++; if ({done, imem_addr} !== {1'b0, 8'h60}) begin miss++;
      $display("FAIL halt_clear: got d%b a%h want 0 60",
               done, imem_addr); end
  endtask

  task automatic test_random;
    logic [8:0] ins;
    logic [7:0] xv, yv;
    do_init(8'h80);
    for (int i = 0; i < 60; i++) begin
      do begin
        ins = 9'($urandom);
      end while ((ins[8] && (ins[7:4] == 4'd12 || ins[7:4] == 4'd13)) ||
                 (!ins[8] && ins[7]));
      xv = 8'($urandom);
      yv = (i % 5 == 0) ? xv : 8'($urandom);
      m_res = exp_res(ins, xv, yv, m_cmp, m_res);
      if (ins[8] && ins[7:4] == 4'd6) m_cmp = (xv == yv);
      run(ins, xv, yv);
      vec++; if (result !== m_res) begin miss++;
        $display("FAIL rnd_result[%0d] ins %h x %h y %h: got %h want %h",
                 i, ins, xv, yv, result, m_res); end
      vec++; if (cmp !== m_cmp) begin miss++;
        $display("FAIL rnd_cmp[%0d]: got %b want %b", i, cmp, m_cmp); end
      vec++; if (inst_type !== exp_type(ins)) begin miss++;
        $display("FAIL rnd_type[%0d] ins %h: got %0d want %0d",
                 i, ins, inst_type, exp_type(ins)); end
      vec++; if (imem_addr !== m_pc) begin miss++;
        $display("FAIL rnd_pc[%0d]: got %h want %h", i, imem_addr, m_pc); end
    end
  endtask

  initial begin
    init = 0; fetch_unit_en = 0; decoder_en = 0; alu_en = 0;
    start_address = 0; x = 0; y = 0;
    for (int i = 0; i < 256; i++) imem[i] = 9'd0;
    @(posedge clk); #1;
    test_reset;
    test_add;
    test_cmp_beqi;
    test_jmp_beq;
    test_shifts;
    test_halt;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
